// File: rtl/mem_phase_sequencer_pkg.sv
// Shared definitions for the unified instruction/data memory sequencer.
package rv32_mem_pkg;

    // Memory phase: FETCH serves the IF stage, DATA serves the MEM stage.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } phase_e;

    // Load/store funct3 encodings.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Data words start here in the unified memory.
    localparam int unsigned DATA_OFFSET = 64;

    // Packed memory address: data word index above instruction word index.
    function automatic logic [11:0] pack_addr(input logic [31:0] d_addr, input logic [31:0] pc);
        return {d_addr[7:2], pc[7:2]};
    endfunction

endpackage

// File: rtl/mem_phase_sequencer_if.sv
// Memory-side bus of the phase sequencer.
interface mem_phase_sequencer_if #(
    parameter int n = 32
) ();
    logic         clkdiv2;
    logic         MemRead;
    logic         MemWrite;
    logic [11:0]  addr;
    logic [2:0]   funct3;
    logic [n-1:0] data_in;
    logic [n-1:0] data_out;

    modport master (
        output clkdiv2, MemRead, MemWrite, addr, funct3, data_in,
        input  data_out
    );

    modport slave (
        input  clkdiv2, MemRead, MemWrite, addr, funct3, data_in,
        output data_out
    );
endinterface

// File: rtl/mem_phase_sequencer_align_check.sv
// Flags word/halfword accesses whose byte address is not naturally aligned.
module mem_align_check (
    input  logic [1:0] width_sel,   // funct3[1:0]
    input  logic [1:0] addr_lo,     // d_addr[1:0]
    output logic       misal_now
);
    // Alignment decode by access width.
    always_comb begin
        misal_now = 1'b0;
        case (width_sel)
            2'b10:   misal_now = |addr_lo;
            2'b01:   misal_now = addr_lo[0];
            default: misal_now = 1'b0;
        endcase
    end
endmodule

// File: rtl/mem_phase_sequencer.sv
// Alternates FETCH and DATA phases on the single-ported unified memory,
// captures the fetched instruction and load data, and strobes pipe_en.
module mem_phase_sequencer
    import rv32_mem_pkg::*;
#(
    parameter int           n   = 32,
    parameter logic [n-1:0] NOP = n'(NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc,
    input  logic                  stall,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [31:0]           d_addr,
    input  logic [2:0]            d_funct3,
    input  logic [n-1:0]          d_wdata,
    mem_phase_sequencer_if.master mem,
    output logic [n-1:0]          inst,
    output logic                  inst_valid,
    output logic [n-1:0]          load_data,
    output logic                  pipe_en,
    output logic                  misalign
);

    phase_e       state_q, state_d;
    logic [n-1:0] inst_q, inst_d;
    logic         inst_valid_q, inst_valid_d;
    logic [n-1:0] load_data_q, load_data_d;
    logic         wr_done_q, wr_done_d;
    logic         misalign_q, misalign_d;

    logic fetch_phase;
    logic data_phase;
    logic misal_now;
    logic mem_read;
    logic mem_write;
    logic pipe_en_c;

    // Address bits outside the 128-word window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[31:8], pc[1:0], d_addr[31:8]};

    mem_align_check u_align (
        .width_sel (d_funct3[1:0]),
        .addr_lo   (d_addr[1:0]),
        .misal_now (misal_now)
    );

    assign fetch_phase = (state_q == FETCH);
    assign data_phase  = (state_q == DATA);

    // Memory strobes decode from the state flop, so reset removes them at once.
    assign mem_read  = data_phase & d_read & ~misal_now;
    assign mem_write = data_phase & d_write & ~wr_done_q & ~misal_now;
    assign pipe_en_c = data_phase & ~stall;

    assign mem.clkdiv2  = fetch_phase;
    assign mem.MemRead  = mem_read;
    assign mem.MemWrite = mem_write;
    assign mem.addr     = pack_addr(d_addr, pc);
    assign mem.funct3   = d_funct3;
    assign mem.data_in  = d_wdata;

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign load_data  = load_data_q;
    assign pipe_en    = pipe_en_c;
    assign misalign   = misalign_q;

    // Next-state: free-running phase toggle plus capture/hold of pipeline-facing registers.
    always_comb begin
        state_d      = (state_q == FETCH) ? DATA : FETCH;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        load_data_d  = load_data_q;
        wr_done_d    = wr_done_q;
        misalign_d   = misalign_q;

        if (fetch_phase && !stall) begin
            inst_d       = mem.data_out;
            inst_valid_d = 1'b1;
        end

        if (mem_read) begin
            load_data_d = mem.data_out;
        end

        // A store held by stall commits once; the flag lives until the pipeline advances.
        if (pipe_en_c) begin
            wr_done_d = 1'b0;
        end else if (mem_write && stall) begin
            wr_done_d = 1'b1;
        end

        if (data_phase && misal_now && (d_read || d_write)) begin
            misalign_d = 1'b1;
        end
    end

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
            load_data_q  <= '0;
            wr_done_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            load_data_q  <= load_data_d;
            wr_done_q    <= wr_done_d;
            misalign_q   <= misalign_d;
        end
    end

endmodule

// File: tb/tb_mem_phase_sequencer.sv
// Directed bench for mem_phase_sequencer with a behavioural unified memory.
module tb_mem_phase_sequencer;
    import rv32_mem_pkg::*;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
    localparam logic [31:0] WA = 32'h0000_0033;
    localparam logic [31:0] WB = 32'h1111_1111;
    localparam logic [31:0] WC = 32'h2222_2222;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [2:0]  d_funct3;
    logic [31:0] d_wdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] load_data;
    logic        pipe_en;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    mem_phase_sequencer_if #(.n(32)) mif ();

    mem_phase_sequencer #(.n(32), .NOP(32'h0000_0013)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .stall      (stall),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_funct3   (d_funct3),
        .d_wdata    (d_wdata),
        .mem        (mif.master),
        .inst       (inst),
        .inst_valid (inst_valid),
        .load_data  (load_data),
        .pipe_en    (pipe_en),
        .misalign   (misalign)
    );

    // Unified memory: fetch uses addr[5:0], data uses DATA_OFFSET + addr[11:6].
    logic [31:0] mem [128] = '{0: WA, 1: WB, 2: WC, 66: 32'd25, 67: 32'h55, default: 32'h0};
    logic [31:0] snap [128];

    assign mif.data_out = mif.clkdiv2 ? mem[{1'b0, mif.addr[5:0]}]
                                      : mem[7'(DATA_OFFSET) + {1'b0, mif.addr[11:6]}];

    always @(posedge clk) begin
        if (mif.MemWrite) mem[7'(DATA_OFFSET) + {1'b0, mif.addr[11:6]}] <= mif.data_in;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        rd;
        logic        wr;
        logic [31:0] da;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic        e_clk;
        logic        e_mr;
        logic        e_mw;
        logic        e_pe;
        logic [11:0] e_addr;
        logic [31:0] e_inst;
        logic        e_iv;
        logic [31:0] e_ld;
        logic        e_mis;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int diffs;
        //           pc     st rd wr da     f3   wd      clk mr mw pe addr     inst       iv ld      mis
        vecs[0]  = '{32'h0, L, L, L, 32'h00, LW,  32'd0,  H, L, L, L, 12'h000, NOP_INSTR, L, 32'd0,  L};
        vecs[1]  = '{32'h4, L, H, L, 32'h08, LW,  32'd0,  L, H, L, H, 12'h081, WA,        H, 32'd0,  L};
        vecs[2]  = '{32'h4, L, L, L, 32'h08, LW,  32'd0,  H, L, L, L, 12'h081, WA,        H, 32'd25, L};
        vecs[3]  = '{32'h4, H, L, H, 32'h14, SW,  32'd7,  L, L, H, L, 12'h141, WB,        H, 32'd25, L};
        vecs[4]  = '{32'h8, H, L, H, 32'h14, SW,  32'd7,  H, L, L, L, 12'h142, WB,        H, 32'd25, L};
        vecs[5]  = '{32'h8, H, L, H, 32'h14, SW,  32'd7,  L, L, L, L, 12'h142, WB,        H, 32'd25, L};
        vecs[6]  = '{32'h8, H, L, H, 32'h14, SW,  32'd7,  H, L, L, L, 12'h142, WB,        H, 32'd25, L};
        vecs[7]  = '{32'h8, H, L, H, 32'h14, SW,  32'd7,  L, L, L, L, 12'h142, WB,        H, 32'd25, L};
        vecs[8]  = '{32'h8, L, L, H, 32'h14, SW,  32'd7,  H, L, L, L, 12'h142, WB,        H, 32'd25, L};
        vecs[9]  = '{32'h8, L, L, H, 32'h14, SW,  32'd7,  L, L, L, H, 12'h142, WC,        H, 32'd25, L};
        vecs[10] = '{32'h8, L, L, L, 32'h14, SW,  32'd0,  H, L, L, L, 12'h142, WC,        H, 32'd25, L};
        vecs[11] = '{32'h8, L, H, L, 32'h03, LH,  32'd0,  L, L, L, H, 12'h002, WC,        H, 32'd25, L};
        vecs[12] = '{32'h8, L, L, L, 32'h03, LH,  32'd0,  H, L, L, L, 12'h002, WC,        H, 32'd25, H};
        vecs[13] = '{32'h8, L, H, L, 32'h08, LW,  32'd0,  L, H, L, H, 12'h082, WC,        H, 32'd25, H};
        vecs[14] = '{32'h8, L, L, L, 32'h08, LW,  32'd0,  H, L, L, L, 12'h082, WC,        H, 32'd25, H};
        vecs[15] = '{32'h8, L, H, H, 32'h08, LW,  32'd99, L, H, H, H, 12'h082, WC,        H, 32'd25, H};
        vecs[16] = '{32'h8, L, L, L, 32'h08, LW,  32'd0,  H, L, L, L, 12'h082, WC,        H, 32'd25, H};
        vecs[17] = '{32'h8, L, H, L, 32'h08, LW,  32'd0,  L, H, L, H, 12'h082, WC,        H, 32'd25, H};
        vecs[18] = '{32'h8, L, L, L, 32'h08, LW,  32'd0,  H, L, L, L, 12'h082, WC,        H, 32'd99, H};
        vecs[19] = '{32'h8, L, H, L, 32'h0F, LBU, 32'd0,  L, H, L, H, 12'h0C2, WC,        H, 32'd99, H};
        vecs[20] = '{32'h8, L, L, L, 32'h00, LW,  32'd0,  H, L, L, L, 12'h002, WC,        H, 32'h55, H};

        // Reset held with requests asserted: everything at reset values.
        rst_n = 1'b0; pc = '0; stall = 1'b0; d_read = 1'b1; d_write = 1'b1;
        d_addr = 32'h08; d_funct3 = LW; d_wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_clkdiv2",    32'(mif.clkdiv2),  32'd1);
        chk("rst_memread",    32'(mif.MemRead),  32'd0);
        chk("rst_memwrite",   32'(mif.MemWrite), 32'd0);
        chk("rst_pipe_en",    32'(pipe_en),      32'd0);
        chk("rst_inst",       inst,              NOP_INSTR);
        chk("rst_inst_valid", 32'(inst_valid),   32'd0);
        chk("rst_load_data",  load_data,         32'd0);
        chk("rst_misalign",   32'(misalign),     32'd0);

        // One row per cycle: drive at negedge, compare 1 time unit later.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n    = 1'b1;
            pc       = vecs[i].pc;
            stall    = vecs[i].stall;
            d_read   = vecs[i].rd;
            d_write  = vecs[i].wr;
            d_addr   = vecs[i].da;
            d_funct3 = vecs[i].f3;
            d_wdata  = vecs[i].wd;
            #1;
            chk($sformatf("r%0d_clkdiv2", i),    32'(mif.clkdiv2),  32'(vecs[i].e_clk));
            chk($sformatf("r%0d_memread", i),    32'(mif.MemRead),  32'(vecs[i].e_mr));
            chk($sformatf("r%0d_memwrite", i),   32'(mif.MemWrite), 32'(vecs[i].e_mw));
            chk($sformatf("r%0d_pipe_en", i),    32'(pipe_en),      32'(vecs[i].e_pe));
            chk($sformatf("r%0d_addr", i),       32'(mif.addr),     32'(vecs[i].e_addr));
            chk($sformatf("r%0d_funct3", i),     32'(mif.funct3),   32'(vecs[i].f3));
            chk($sformatf("r%0d_inst", i),       inst,              vecs[i].e_inst);
            chk($sformatf("r%0d_inst_valid", i), 32'(inst_valid),   32'(vecs[i].e_iv));
            chk($sformatf("r%0d_load_data", i),  load_data,         vecs[i].e_ld);
            chk($sformatf("r%0d_misalign", i),   32'(misalign),     32'(vecs[i].e_mis));
        end

        // Stalled store landed once; combined read/write updated word 66.
        @(posedge clk);
        #1;
        chk("mem69_store", mem[69], 32'd7);
        chk("mem66_rw",    mem[66], 32'd99);

        // Reset asserted mid-DATA with a store pending.
        @(negedge clk);
        d_write = 1'b1; d_read = 1'b0; d_addr = 32'h18; d_funct3 = SW;
        d_wdata = 32'hDEAD_BEEF; stall = 1'b0;
        #1;
        chk("mid_pre_clkdiv2",  32'(mif.clkdiv2),  32'd0);
        chk("mid_pre_memwrite", 32'(mif.MemWrite), 32'd1);
        for (int k = 0; k < 128; k++) snap[k] = mem[k];
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_memwrite",   32'(mif.MemWrite), 32'd0);
        chk("mid_clkdiv2",    32'(mif.clkdiv2),  32'd1);
        chk("mid_pipe_en",    32'(pipe_en),      32'd0);
        chk("mid_inst",       inst,              NOP_INSTR);
        chk("mid_inst_valid", 32'(inst_valid),   32'd0);
        chk("mid_load_data",  load_data,         32'd0);
        chk("mid_misalign",   32'(misalign),     32'd0);
        @(posedge clk);
        #1;
        diffs = 0;
        for (int k = 0; k < 128; k++) if (mem[k] !== snap[k]) diffs++;
        chk("mid_mem_unchanged", 32'(diffs), 32'd0);
        chk("mid_mem70",         mem[70],    32'd0);

        // Release: first cycle is FETCH, then DATA with an advance.
        @(negedge clk);
        d_write = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_clkdiv2_fetch", 32'(mif.clkdiv2), 32'd1);
        chk("rel_pipe_en_fetch", 32'(pipe_en),     32'd0);
        @(negedge clk);
        #1;
        chk("rel_clkdiv2_data",  32'(mif.clkdiv2), 32'd0);
        chk("rel_pipe_en_data",  32'(pipe_en),     32'd1);
        chk("rel_inst",          inst,             WC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_phase_sequencer.md
# mem_phase_sequencer

Sequences every access to the pipeline's single-ported unified instruction/data memory, which has 128 words: words 0–63 hold instructions and words 64–127 hold data. The block sits between the IF stage and the MEM stage on one side and the memory on the other. It alternates a FETCH phase and a DATA phase, drives the memory's `clkdiv2` phase select, and packs the memory address. It captures the fetched instruction and the formatted load data into registers. It issues `pipe_en`, which advances the pipeline registers once per FETCH+DATA pair.

## Interface
Parameters:
- `n`, 32: data/instruction width.
- `NOP`, 32'h0000_0013: instruction value presented after reset and on invalid fetch.

Ports:
- `clk`  in  1: single clock. Every register and the memory's write port use this clock.
- `rst_n`  in  1: reset. It is asynchronous and active-low.
- `pc`  in  32: IF-stage byte PC. Bits [7:2] select the instruction word.
- `stall`  in  1: hold request from the hazard unit.
- `d_read`  in  1: MEM-stage load request.
- `d_write`  in  1: MEM-stage store request.
- `d_addr`  in  32: MEM-stage byte address. Bits [7:2] select the data word.
- `d_funct3`  in  3: load/store type.
- `d_wdata`  in  n: store data.
- `clkdiv2`  out  1: memory phase select. 1 = fetch, 0 = data.
- `MemRead`  out  1: memory read enable.
- `MemWrite`  out  1: memory write enable.
- `addr`  out  12: packed memory address, `{d_addr[7:2], pc[7:2]}`.
- `funct3`  out  3: passed through from `d_funct3`.
- `data_in`  out  n: memory write data.
- `data_out`  in  n: memory read data. The memory returns it combinationally.
- `inst`  out  n: registered instruction for the ID stage.
- `inst_valid`  out  1: `inst` holds a real fetch.
- `load_data`  out  n: registered, already-formatted load result.
- `pipe_en`  out  1: pipeline-register advance strobe.
- `misalign`  out  1: sticky misaligned-access error.

## Operation
- Phase FSM has two states, FETCH and DATA. Transitions: reset → FETCH; FETCH → DATA and DATA → FETCH every cycle, unconditionally. `stall` never freezes the phase.
- `clkdiv2` = (state == FETCH). It is decoded combinationally from the state register.
- FETCH cycle:
  - `MemRead` = 0 and `MemWrite` = 0.
  - At the posedge, `inst` ← `data_out` and `inst_valid` ← 1, unless `stall` = 1, in which case both hold.
- DATA cycle:
  - `MemRead` = `d_read` & ~`misal_now`.
  - `MemWrite` = `d_write` & ~`wr_done` & ~`misal_now`.
  - At the posedge, `load_data` ← `data_out` when `MemRead` = 1; otherwise it holds.
- `pipe_en` = (state == DATA) & ~`stall`.
- `wr_done` is an internal register:
  - Set at a DATA posedge where `MemWrite` = 1 and `stall` = 1.
  - Cleared at any posedge where `pipe_en` = 1.
  - Effect: a stalled store commits exactly once.
- `misal_now` is the misalignment condition:
  - Word access (funct3[1:0] = 2'b10) with `d_addr[1:0]` ≠ 0.
  - Halfword access (funct3[1:0] = 2'b01) with `d_addr[0]` = 1.
- `misalign`:
  - Set at a DATA posedge where `misal_now` & (`d_read` | `d_write`).
  - Cleared only by reset.
  - The offending access is suppressed.
- `d_read` and `d_write` both high: the read is performed, the write is performed, and the store path takes priority for `data_in`. The memory returns the pre-write value to `load_data`.
- `data_in` = `d_wdata` in both phases. It is ignored by the memory unless `MemWrite` = 1.

## Timing
- Reset values:
  - state = FETCH, `clkdiv2` = 1.
  - `inst` = NOP, `inst_valid` = 0.
  - `load_data` = 0, `pipe_en` = 0.
  - `wr_done` = 0, `misalign` = 0.
  - `MemRead` = 0, `MemWrite` = 0.
- Fetch latency: `pc` presented in the FETCH cycle; `inst` is valid in the following (DATA) cycle.
- Load latency: `d_addr` presented in the DATA cycle; `load_data` is valid in the next FETCH cycle.
- Throughput: one pipeline advance every 2 cycles. `pipe_en` is high at most once per 2 cycles.
- Reset asserted mid-DATA: `MemWrite` drops immediately, asynchronously, so no write commits at the next edge. After deassertion, the first cycle is FETCH.
- Store commit: at the posedge ending the DATA cycle in which `MemWrite` = 1.

## Structure
- Shared package `rv32_mem_pkg` holds:
  - Phase state enum: FETCH, DATA.
  - Load/store funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - `NOP` constant.
  - `DATA_OFFSET` = 64.
- One natural sub-module is `mem_align_check`. It is combinational and takes funct3 and `d_addr[1:0]`, producing `misal_now`.
- All other logic stays in the top module.

## Test plan
- Reset release with `pc` = 0 and memory word 0 = 32'h0000_0033: `clkdiv2` reads 1, 0, 1; `inst` = 32'h0000_0033 with `inst_valid` = 1 one cycle after the first FETCH; `pipe_en` pulses every second cycle.
- Load word, `d_read` = 1, `d_addr` = 32'h08, memory word 66 = 25: `addr[11:6]` = 2 during DATA; `load_data` = 25 in the next FETCH cycle.
- Store word held by `stall` = 1 for 3 DATA phases, `d_addr` = 32'h14, `d_wdata` = 7: `MemWrite` is high in exactly one DATA cycle; memory word 69 = 7.
- Halfword access at `d_addr` = 32'h03: `MemRead`/`MemWrite` stay 0; `misalign` = 1 and stays 1 until reset.
- `stall` = 1 across a FETCH phase with `pc` changing from 4 to 8: `inst` keeps the pc=4 word; `pipe_en` = 0.
- `rst_n` pulled low during a DATA cycle with `d_write` = 1: no memory word changes; all outputs return to their reset values; the first cycle after release is FETCH.
